// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter.
//   - state_t         : sequencer states (IDLE waits for a request and grants it,
//                       ACCESS drives the memory strobes for one cycle)
//   - owner_t         : which requester owns the access in flight
//   - WORD_ALIGN_MASK : low address bits that must be zero for a word access
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // One-hot grant vector to owner encoding (bit 1 set means requester 1).
  function automatic owner_t onehot_to_owner(input logic [1:0] onehot);
    return onehot[1] ? OWNER_M1 : OWNER_M0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin picker, purely combinational.
//   Ports:
//     req[1:0]  in   request lines, bit 0 = m0, bit 1 = m1
//     last_gnt  in   owner granted most recently
//     gnt[1:0]  out  one-hot pick (all zero when nothing is requesting)
//   A lone request always wins; on a tie the requester that was not granted
//   last time wins, which bounds the wait of either side to one access.
// -----------------------------------------------------------------------------
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == OWNER_M1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Round-robin arbiter and sequencer in front of a data memory with a
//   combinational read port and a posedge write port. Port m0 is the core
//   load/store unit, port m1 the DMA/debug loader. Accesses are serialised,
//   checked for word alignment and range, and answered with a registered
//   response one cycle after the memory strobe.
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     m0_req/we/addr/wdata       requester 0 command (held until m0_gnt)
//     m0_gnt                     command accepted this cycle (IDLE only)
//     m0_done                    one-cycle completion pulse for requester 0
//     m1_*                       same set for requester 1
//     rsp_rdata, rsp_err         response of the access that just completed
//     memread, memwrite          strobes to data memory (never both high)
//     address, write_data        registered address/data to data memory
//     read_data                  combinational read data from data memory
//
//   Timing: grant in cycle N, strobe in N+1, done in N+2. The done cycle is
//   an IDLE cycle, so the next grant can overlap it (one access per 2 cycles).
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,

  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  state_t              state;
  owner_t              last_gnt;
  owner_t              owner_q;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                memread_q;
  logic                memwrite_q;
  logic [1:0]          done_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic [1:0]          pick;
  logic [1:0]          gnt_vec;
  owner_t              win;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_err;

  rr_arb2 u_rr_arb2 (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // Grants exist only in IDLE. rst_n is folded in so a request held across
  // reset can never see a grant while the block is still held in reset.
  assign gnt_vec = (rst_n && (state == IDLE)) ? pick : 2'b00;
  assign m0_gnt  = gnt_vec[0];
  assign m1_gnt  = gnt_vec[1];

  // Command of the winning requester, and its error check.
  always_comb begin
    win       = onehot_to_owner(gnt_vec);
    sel_we    = (win == OWNER_M1) ? m1_we    : m0_we;
    sel_addr  = (win == OWNER_M1) ? m1_addr  : m0_addr;
    sel_wdata = (win == OWNER_M1) ? m1_wdata : m0_wdata;
    sel_err   = ((sel_addr[1:0] & WORD_ALIGN_MASK) != 2'b00) ||
                (sel_addr >= MEM_LIMIT);
  end

  // Sequencer. Strobes are registered at the grant edge so they are high for
  // exactly the ACCESS cycle; an errored access gets no strobe at all, which
  // also keeps out-of-range addresses from aliasing onto real locations.
  // The asynchronous reset clears the strobes immediately, so a write caught
  // mid-ACCESS never reaches its commit edge and no done is issued for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_gnt    <= OWNER_M1;
      owner_q     <= OWNER_M0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      done_q      <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      done_q <= 2'b00;
      unique case (state)
        IDLE: begin
          if (gnt_vec != 2'b00) begin
            state      <= ACCESS;
            owner_q    <= win;
            last_gnt   <= win;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            err_q      <= sel_err;
            memread_q  <= !sel_we && !sel_err;
            memwrite_q <= sel_we && !sel_err;
          end
        end
        ACCESS: begin
          state      <= IDLE;
          memread_q  <= 1'b0;
          memwrite_q <= 1'b0;
          done_q     <= (owner_q == OWNER_M1) ? 2'b10 : 2'b01;
          rsp_err_q  <= err_q;
          // Read data is captured on the same edge that commits a write.
          rsp_rdata_q <= (!we_q && !err_q) ? read_data : '0;
        end
        default: begin
          state      <= IDLE;
          memread_q  <= 1'b0;
          memwrite_q <= 1'b0;
        end
      endcase
    end
  end

  assign memread    = memread_q;
  assign memwrite   = memwrite_q;
  assign address    = addr_q;
  assign write_data = wdata_q;
  assign m0_done    = done_q[0];
  assign m1_done    = done_q[1];
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 1024;

  logic              clk;
  logic              rst_n;
  logic              m0_req, m0_we, m0_gnt, m0_done;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m1_req, m1_we, m1_gnt, m1_done;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              memread, memwrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  int checks = 0;
  int errors = 0;

  // Data memory model: combinational read, posedge write, 256 words.
  logic [DATA_W-1:0] mem [256];
  assign read_data = mem[address[9:2]];
  always @(posedge clk) begin
    if (memwrite) mem[address[9:2]] <= write_data;
  end

  dmem_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_done    (m0_done),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_done    (m1_done),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .memread    (memread),
    .memwrite   (memwrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

    // 1: reset with both requesters already asking
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4; m1_wdata = 32'h0;
    tick(); tick();
    chk("rst_m0_gnt",   {31'b0, m0_gnt},   32'h0);
    chk("rst_m1_gnt",   {31'b0, m1_gnt},   32'h0);
    chk("rst_m0_done",  {31'b0, m0_done},  32'h0);
    chk("rst_m1_done",  {31'b0, m1_done},  32'h0);
    chk("rst_memread",  {31'b0, memread},  32'h0);
    chk("rst_memwrite", {31'b0, memwrite}, 32'h0);
    chk("rst_address",  address,           32'h0);
    chk("rst_wdata",    write_data,        32'h0);
    chk("rst_rdata",    rsp_rdata,         32'h0);
    chk("rst_err",      {31'b0, rsp_err},  32'h0);

    // 3: continuous contention from reset release, m0 wins first
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr_N_gnt0", {31'b0, m0_gnt}, 32'h1);
    chk("rr_N_gnt1", {31'b0, m1_gnt}, 32'h0);
    tick();
    chk("rr_N1_gnt0",    {31'b0, m0_gnt},  32'h0);
    chk("rr_N1_gnt1",    {31'b0, m1_gnt},  32'h0);
    chk("rr_N1_memread", {31'b0, memread}, 32'h1);
    chk("rr_N1_addr",    address,          32'h0);
    tick();
    chk("rr_N2_done0", {31'b0, m0_done}, 32'h1);
    chk("rr_N2_rdata", rsp_rdata,        32'hA000_0000);
    chk("rr_N2_gnt1",  {31'b0, m1_gnt},  32'h1);
    chk("rr_N2_gnt0",  {31'b0, m0_gnt},  32'h0);
    tick();
    chk("rr_N3_memread", {31'b0, memread}, 32'h1);
    chk("rr_N3_addr",    address,          32'h4);
    tick();
    chk("rr_N4_done1", {31'b0, m1_done}, 32'h1);
    chk("rr_N4_rdata", rsp_rdata,        32'hA000_0001);
    chk("rr_N4_gnt0",  {31'b0, m0_gnt},  32'h1);
    chk("rr_N4_gnt1",  {31'b0, m1_gnt},  32'h0);
    tick();
    tick();
    chk("rr_N6_done0", {31'b0, m0_done}, 32'h1);
    chk("rr_N6_gnt1",  {31'b0, m1_gnt},  32'h1);
    chk("rr_N6_gnt0",  {31'b0, m0_gnt},  32'h0);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    chk("rr_N8_done1", {31'b0, m1_done}, 32'h1);
    chk("rr_N8_rdata", rsp_rdata,        32'hA000_0001);
    chk("rr_N8_gnt0",  {31'b0, m0_gnt},  32'h0);

    // 2: m0 write 0x10, then m1 reads it back
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt0", {31'b0, m0_gnt}, 32'h1);
    tick();
    m0_req = 1'b0;
    chk("wr_memwrite", {31'b0, memwrite}, 32'h1);
    chk("wr_memread",  {31'b0, memread},  32'h0);
    chk("wr_address",  address,           32'h10);
    chk("wr_wdata",    write_data,        32'hDEAD_BEEF);
    chk("wr_gnt0_acc", {31'b0, m0_gnt},   32'h0);
    tick();
    chk("wr_done0", {31'b0, m0_done}, 32'h1);
    chk("wr_err",   {31'b0, rsp_err}, 32'h0);
    chk("wr_rdata", rsp_rdata,        32'h0);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
    #1;
    chk("rd_gnt1", {31'b0, m1_gnt}, 32'h1);
    tick();
    m1_req = 1'b0;
    chk("rd_memread", {31'b0, memread}, 32'h1);
    tick();
    chk("rd_done1", {31'b0, m1_done}, 32'h1);
    chk("rd_done0", {31'b0, m0_done}, 32'h0);
    chk("rd_rdata", rsp_rdata,        32'hDEAD_BEEF);

    // 4: misaligned read by m1
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h13;
    #1;
    chk("mis_gnt1", {31'b0, m1_gnt}, 32'h1);
    tick();
    m1_req = 1'b0;
    chk("mis_memread",  {31'b0, memread},  32'h0);
    chk("mis_memwrite", {31'b0, memwrite}, 32'h0);
    tick();
    chk("mis_done1", {31'b0, m1_done}, 32'h1);
    chk("mis_err",   {31'b0, rsp_err}, 32'h1);
    chk("mis_rdata", rsp_rdata,        32'h0);

    // 5: out-of-range write by m0, then mem[0] still intact
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h400; m0_wdata = 32'hCAFE_F00D;
    #1;
    chk("oor_gnt0", {31'b0, m0_gnt}, 32'h1);
    tick();
    m0_req = 1'b0;
    chk("oor_memwrite", {31'b0, memwrite}, 32'h0);
    chk("oor_memread",  {31'b0, memread},  32'h0);
    tick();
    chk("oor_done0", {31'b0, m0_done}, 32'h1);
    chk("oor_err",   {31'b0, rsp_err}, 32'h1);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    tick();
    m0_req = 1'b0;
    tick();
    chk("oor_rd_done0", {31'b0, m0_done}, 32'h1);
    chk("oor_rd_err",   {31'b0, rsp_err}, 32'h0);
    chk("oor_rd_rdata", rsp_rdata,        32'hA000_0000);

    // 6: reset asserted in the middle of a write ACCESS
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h1234_5678;
    #1;
    chk("ar_gnt0", {31'b0, m0_gnt}, 32'h1);
    tick();
    chk("ar_memwrite_acc", {31'b0, memwrite}, 32'h1);
    rst_n = 1'b0;
    m0_req = 1'b0;
    #1;
    chk("ar_memwrite_drop", {31'b0, memwrite}, 32'h0);
    chk("ar_memread_drop",  {31'b0, memread},  32'h0);
    tick();
    chk("ar_done0_a", {31'b0, m0_done}, 32'h0);
    tick();
    chk("ar_done0_b", {31'b0, m0_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    #1;
    chk("ar_rd_gnt1", {31'b0, m1_gnt}, 32'h1);
    tick();
    m1_req = 1'b0;
    tick();
    chk("ar_rd_done1", {31'b0, m1_done}, 32'h1);
    chk("ar_rd_rdata", rsp_rdata,        32'hA000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
